// File: rtl/serial_mod_residue_pkg.sv
// Shared types and constants for the serial modulo-N residue engine.
package serial_mod_pkg;

    // Bit order of a word, latched on its first bit.
    localparam logic MODE_LSB = 1'b0;
    localparam logic MODE_MSB = 1'b1;

    // Word framing state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Ceiling log2 with a floor of 1, used to size residue and count registers.
    function automatic int clog2_w(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_mod_residue_if.sv
// Serial bit stream in, residue/status out, for the residue engine.
//
// Handshake: the engine is always ready. A beat (in_bit, in_last,
// in_msb_first) is accepted at a rising clk edge whenever in_valid=1 and
// clear=0; there is no backpressure. Result outputs are registered and change
// only at the edge that accepts a beat, or on clear/reset.
interface serial_mod_residue_if #(
    parameter int RW = 3,
    parameter int CW = 6
) ();
    import serial_mod_pkg::*;

    logic          clear;
    logic          in_valid;
    logic          in_bit;
    logic          in_last;
    logic          in_msb_first;
    logic [RW-1:0] residue;
    logic          divisible;
    logic [CW-1:0] bit_count;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    modport master (
        output clear, in_valid, in_bit, in_last, in_msb_first,
        input  residue, divisible, bit_count, busy, done, dbg_state
    );

    modport slave (
        input  clear, in_valid, in_bit, in_last, in_msb_first,
        output residue, divisible, bit_count, busy, done, dbg_state
    );

endinterface

// File: rtl/serial_mod_residue_add_reduce.sv
// Combinational (a + b + cin) mod MOD for operands already reduced below MOD.
// The carry-in lets the MSB-first step compute 2r + bit in one adder; the
// caller guarantees the raw sum stays below 2*MOD, so one conditional
// subtract is enough.
module mod_add_reduce #(
    parameter int MOD = 5,
    parameter int RW  = 3
) (
    input  logic [RW-1:0] a_i,
    input  logic [RW-1:0] b_i,
    input  logic          cin_i,
    output logic [RW-1:0] sum_o
);
    localparam logic [RW:0]   MOD_W  = (RW + 1)'(MOD);
    // Low bits of MOD; modular RW-bit subtraction gives the right result
    // even when MOD is exactly 2**RW.
    localparam logic [RW-1:0] MOD_LO = RW'(MOD);

    logic [RW:0] raw;

    assign raw = {1'b0, a_i} + {1'b0, b_i} + {{RW{1'b0}}, cin_i};

    // Single compare-and-subtract reduction.
    always_comb begin
        sum_o = raw[RW-1:0];
        if (raw >= MOD_W) begin
            sum_o = raw[RW-1:0] - MOD_LO;
        end
    end

endmodule

// File: rtl/serial_mod_residue.sv
// Serial modulo-MOD residue engine: folds one bit per accepted beat into a
// running residue, LSB-first or MSB-first per word, with word framing.
module serial_mod_residue
    import serial_mod_pkg::*;
#(
    parameter int MOD     = 5,
    parameter int MAX_LEN = 32,
    parameter int RW      = clog2_w(MOD),
    parameter int CW      = clog2_w(MAX_LEN + 1)
) (
    input logic             clk,
    input logic             reset,
    serial_mod_residue_if.slave bus
);
    localparam logic [RW-1:0] ONE_R = RW'(1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [RW-1:0] weight_q, weight_d;
    logic [RW-1:0] residue_q, residue_d;
    logic [CW-1:0] count_q, count_d;
    logic          div_q, div_d;
    logic          done_q, done_d;

    logic          accept;
    logic          first;
    logic          cur_mode;
    logic [RW-1:0] base_res;
    logic [RW-1:0] base_w;
    logic [CW-1:0] base_cnt;
    logic [CW-1:0] next_cnt;
    logic [RW-1:0] lsb_addend;
    logic [RW-1:0] msb_next;
    logic [RW-1:0] lsb_next;
    logic [RW-1:0] w_next;

    // clear beats in_valid: a bit presented together with clear is dropped.
    assign accept = bus.in_valid && !bus.clear;
    assign first  = (state_q == ST_IDLE);

    // A first bit starts from residue 0, weight 1, count 0 regardless of
    // what the previous word left behind.
    assign base_res   = first ? '0 : residue_q;
    assign base_w     = first ? ONE_R : weight_q;
    assign base_cnt   = first ? '0 : count_q;
    assign cur_mode   = first ? bus.in_msb_first : mode_q;
    assign next_cnt   = (base_cnt >= MAX_C) ? MAX_C : base_cnt + CW'(1);
    assign lsb_addend = bus.in_bit ? base_w : '0;

    // MSB-first: r' = 2r + b.
    mod_add_reduce #(.MOD(MOD), .RW(RW)) u_add_msb (
        .a_i   (base_res),
        .b_i   (base_res),
        .cin_i (bus.in_bit),
        .sum_o (msb_next)
    );

    // LSB-first: r' = r + b*w.
    mod_add_reduce #(.MOD(MOD), .RW(RW)) u_add_lsb (
        .a_i   (base_res),
        .b_i   (lsb_addend),
        .cin_i (1'b0),
        .sum_o (lsb_next)
    );

    // Weight doubling for the next LSB-first bit.
    mod_add_reduce #(.MOD(MOD), .RW(RW)) u_add_w (
        .a_i   (base_w),
        .b_i   (base_w),
        .cin_i (1'b0),
        .sum_o (w_next)
    );

    // Word framing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next word state: in_last closes the word, clear aborts it.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d = bus.in_last ? ST_IDLE : ST_ACTIVE;
        end
    end

    // Next residue, weight, count, flag and done values.
    always_comb begin
        mode_d    = mode_q;
        weight_d  = weight_q;
        residue_d = residue_q;
        count_d   = count_q;
        div_d     = div_q;
        done_d    = 1'b0;
        if (bus.clear) begin
            weight_d  = ONE_R;
            residue_d = '0;
            count_d   = '0;
            div_d     = 1'b0;
        end else if (accept) begin
            mode_d    = cur_mode;
            residue_d = (cur_mode == MODE_MSB) ? msb_next : lsb_next;
            weight_d  = w_next;
            count_d   = next_cnt;
            div_d     = (residue_d == '0);
            done_d    = bus.in_last;
        end
    end

    // Datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_LSB;
            weight_q  <= ONE_R;
            residue_q <= '0;
            count_q   <= '0;
            div_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            weight_q  <= weight_d;
            residue_q <= residue_d;
            count_q   <= count_d;
            div_q     <= div_d;
            done_q    <= done_d;
        end
    end

    assign bus.residue   = residue_q;
    assign bus.divisible = div_q;
    assign bus.bit_count = count_q;
    assign bus.busy      = (state_q == ST_ACTIVE);
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_mod_residue.sv
// Self-checking bench for serial_mod_residue: a MOD=5 instance and a MOD=7
// instance with a short MAX_LEN so the count saturates.
module tb_serial_mod_residue;
    import serial_mod_pkg::*;

    localparam int W = 16;  // {busy, divisible, count[5:0], residue[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_mod_residue_if #(.RW(3), .CW(6)) bus5 ();
    serial_mod_residue_if #(.RW(3), .CW(4)) bus7 ();

    serial_mod_residue #(.MOD(5), .MAX_LEN(32)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    serial_mod_residue #(.MOD(7), .MAX_LEN(8)) dut7 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus7)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp5_q[$];
    logic [W-1:0] exp7_q[$];
    logic [W-1:0] done5_q[$];
    logic [W-1:0] done7_q[$];
    logic acc5, acc7;

    function automatic logic [W-1:0] pack(input logic busy, input logic div,
                                          input int cnt, input int res);
        return {busy, div, 6'(cnt), 8'(res)};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got busy=%0b div=%0b cnt=%0d res=%0d, expected busy=%0b div=%0b cnt=%0d res=%0d",
                     name, act[15], act[14], act[13:8], act[7:0],
                     exp[15], exp[14], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] snap5();
        return pack(bus5.busy, bus5.divisible, int'(bus5.bit_count), int'(bus5.residue));
    endfunction

    function automatic logic [W-1:0] snap7();
        return pack(bus7.busy, bus7.divisible, int'(bus7.bit_count), int'(bus7.residue));
    endfunction

    // Monitor for the MOD=5 instance: per-beat results and done pulses.
    always begin
        @(posedge clk);
        acc5 = bus5.in_valid && !bus5.clear && !reset;
        @(negedge clk);
        if (acc5) begin
            if (exp5_q.size() == 0) begin
                checks++;
                $display("FAIL beat5: beat accepted with no expectation, res=%0d", bus5.residue);
            end else begin
                check("beat5", snap5(), exp5_q.pop_front());
            end
        end
        if (bus5.done) begin
            if (done5_q.size() == 0) begin
                checks++;
                $display("FAIL done5: unexpected done pulse, got 1 expected 0");
            end else begin
                check("done5", snap5(), done5_q.pop_front());
            end
        end
    end

    // Monitor for the MOD=7 instance.
    always begin
        @(posedge clk);
        acc7 = bus7.in_valid && !bus7.clear && !reset;
        @(negedge clk);
        if (acc7) begin
            if (exp7_q.size() == 0) begin
                checks++;
                $display("FAIL beat7: beat accepted with no expectation, res=%0d", bus7.residue);
            end else begin
                check("beat7", snap7(), exp7_q.pop_front());
            end
        end
        if (bus7.done) begin
            if (done7_q.size() == 0) begin
                checks++;
                $display("FAIL done7: unexpected done pulse, got 1 expected 0");
            end else begin
                check("done7", snap7(), done7_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present one beat for one edge and queue its expected result.
    task automatic beat(input int d, input logic b, input logic last, input logic msb,
                        input int res, input int cnt, input logic div, input logic busy);
        if (d == 5) begin
            bus5.in_valid = 1'b1; bus5.in_bit = b; bus5.in_last = last; bus5.in_msb_first = msb;
            exp5_q.push_back(pack(busy, div, cnt, res));
            if (last) done5_q.push_back(pack(1'b0, div, cnt, res));
        end else begin
            bus7.in_valid = 1'b1; bus7.in_bit = b; bus7.in_last = last; bus7.in_msb_first = msb;
            exp7_q.push_back(pack(busy, div, cnt, res));
            if (last) done7_q.push_back(pack(1'b0, div, cnt, res));
        end
        @(posedge clk); #1;
        bus5.in_valid = 1'b0;
        bus7.in_valid = 1'b0;
    endtask

    task automatic stall(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send a whole word from a table; toggle flips in_msb_first after bit 0.
    task automatic run_word(input int d, input logic msb, input int n,
                            input int bits[10], input int res[10], input int max_len,
                            input int stall_n, input logic toggle);
        for (int i = 0; i < n; i++) begin
            int   cnt;
            logic m;
            cnt = (i + 1 > max_len) ? max_len : i + 1;
            m   = (toggle && i > 0) ? !msb : msb;
            beat(d, bits[i] != 0, i == n - 1, m, res[i], cnt, res[i] == 0, i != n - 1);
            if (stall_n > 0 && i != n - 1) stall(stall_n);
        end
    endtask

    // ---------------- stimulus ----------------
    int w_lsb27_b[10] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    int w_lsb27_r[10] = '{1, 3, 3, 1, 2, 2, 0, 0, 0, 0};
    int w_msb31_b[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int w_msb31_r[10] = '{1, 3, 2, 0, 1, 0, 0, 0, 0, 0};
    int w7_msb_b[10]  = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 0};
    int w7_msb_r[10]  = '{1, 3, 6, 6, 5, 4, 2, 4, 2, 4};
    int w7_lsb_b[10]  = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    int w7_lsb_r[10]  = '{0, 2, 2, 3, 5, 5, 6, 6, 3, 4};

    initial begin
        reset = 1'b1;
        bus5.clear = 1'b0; bus5.in_valid = 1'b0; bus5.in_bit = 1'b0;
        bus5.in_last = 1'b0; bus5.in_msb_first = 1'b0;
        bus7.clear = 1'b0; bus7.in_valid = 1'b0; bus7.in_bit = 1'b0;
        bus7.in_last = 1'b0; bus7.in_msb_first = 1'b0;
        stall(2);

        // Reset state.
        check("reset5", snap5(), pack(0, 0, 0, 0));
        check("reset7", snap7(), pack(0, 0, 0, 0));
        check_val("reset5_done", int'(bus5.done), 0);
        check_val("reset5_state", int'(bus5.dbg_state), int'(ST_IDLE));
        reset = 1'b0;
        stall(2);

        // LSB-first 27 mod 5.
        run_word(5, MODE_LSB, 6, w_lsb27_b, w_lsb27_r, 32, 0, 1'b0);
        stall(3);
        check("hold5_idle", snap5(), pack(0, 0, 6, 2));

        // MSB-first 31 mod 5; divisible only after bit 4.
        run_word(5, MODE_MSB, 5, w_msb31_b, w_msb31_r, 32, 0, 1'b0);
        stall(2);

        // Same LSB word with stalls and in_msb_first flipped mid-word.
        run_word(5, MODE_LSB, 6, w_lsb27_b, w_lsb27_r, 32, 2, 1'b1);
        stall(2);

        // Seven-modulus instance: 858 in both orders; count saturates at 8.
        run_word(7, MODE_MSB, 10, w7_msb_b, w7_msb_r, 8, 0, 1'b0);
        stall(2);
        run_word(7, MODE_LSB, 10, w7_lsb_b, w7_lsb_r, 8, 0, 1'b0);
        stall(3);
        check("hold7_sat", snap7(), pack(0, 0, 8, 4));

        // Reset mid-word, then a fresh MSB-first 1,0,1.
        beat(5, 1, 0, 1, 1, 1, 0, 1);
        beat(5, 1, 0, 1, 3, 2, 0, 1);
        beat(5, 1, 0, 1, 2, 3, 0, 1);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("midreset5", snap5(), pack(0, 0, 0, 0));
        check_val("midreset5_state", int'(bus5.dbg_state), int'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        stall(1);
        beat(5, 1, 0, 1, 1, 1, 0, 1);
        beat(5, 0, 0, 1, 2, 2, 0, 1);
        beat(5, 1, 1, 1, 0, 3, 1, 0);
        stall(2);

        // clear together with a valid last bit: bit dropped, no done.
        beat(5, 1, 0, 1, 1, 1, 0, 1);
        beat(5, 1, 0, 1, 3, 2, 0, 1);
        bus5.clear = 1'b1; bus5.in_valid = 1'b1; bus5.in_bit = 1'b1; bus5.in_last = 1'b1;
        @(posedge clk); #1;
        bus5.clear = 1'b0; bus5.in_valid = 1'b0; bus5.in_last = 1'b0;
        check("clear5", snap5(), pack(0, 0, 0, 0));
        check_val("clear5_done", int'(bus5.done), 0);
        stall(2);

        // Single-bit word.
        beat(5, 1, 1, 0, 1, 1, 0, 0);
        stall(2);

        // Back-to-back: LSB 1,0,1 (5) then MSB 1,0 (2) with no gap.
        beat(5, 1, 0, 0, 1, 1, 0, 1);
        beat(5, 0, 0, 0, 1, 2, 0, 1);
        beat(5, 1, 1, 0, 0, 3, 1, 0);
        beat(5, 1, 0, 1, 1, 1, 0, 1);
        beat(5, 0, 1, 1, 2, 2, 0, 0);
        stall(4);

        // Every queued expectation must have been consumed.
        check_val("leftover_beat5", exp5_q.size(), 0);
        check_val("leftover_beat7", exp7_q.size(), 0);
        check_val("leftover_done5", done5_q.size(), 0);
        check_val("leftover_done7", done7_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
